// File: rtl/event_part_pkg.sv
// Shared types and constants for the xPart/yPart event-pair receive path.
package event_part_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam logic [1:0] BKT_ZERO = 2'd0;
    localparam logic [1:0] BKT_LOW  = 2'd1;
    localparam logic [1:0] BKT_MID  = 2'd2;
    localparam logic [1:0] BKT_HIGH = 2'd3;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_INV = 1'b1;

endpackage

// File: rtl/part_range_classify.sv
// Combinational range-bucket tag for a decoded word; also usable on the transmit side.
module part_range_classify
    import event_part_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [7:0]  TH1   = 8'd16,
    parameter logic [7:0]  TH2   = 8'd64
) (
    input  logic [WIDTH:0] data_i,
    output logic [1:0]     bucket_o
);

    // Compare at the wider of the data and threshold widths so thresholds are never truncated.
    localparam int unsigned CMPW = (WIDTH + 1 > 8) ? WIDTH + 1 : 8;

    logic [CMPW-1:0] val;
    logic [CMPW-1:0] t1;
    logic [CMPW-1:0] t2;

    assign val = CMPW'(data_i);
    assign t1  = CMPW'(TH1);
    assign t2  = CMPW'(TH2);

    always_comb begin
        bucket_o = BKT_HIGH;
        if (val == '0) begin
            bucket_o = BKT_ZERO;
        end else if (val <= t1) begin
            bucket_o = BKT_LOW;
        end else if (val <= t2) begin
            bucket_o = BKT_MID;
        end
    end

endmodule

// File: rtl/event_part_decoder.sv
// Rebuilds operand words from serial (x, y, c) event pairs, LSB first, and tags the result range.
module event_part_decoder
    import event_part_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [7:0]  TH1   = 8'd16,
    parameter logic [7:0]  TH2   = 8'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_x,
    input  logic             in_y,
    input  logic             in_c,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH:0]   out_data,
    output logic [WIDTH-1:0] out_mask,
    output logic [1:0]       out_bucket,
    output logic             out_err
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       bkt_q, bkt_d;

    logic [WIDTH-1:0] x_ins, y_ins;
    logic [WIDTH:0]   dec_data;
    logic [WIDTH-1:0] dec_mask;
    logic [1:0]       dec_bkt;
    logic             accept;

    assign in_ready   = (state_q != HOLD) || out_ready;
    assign out_valid  = (state_q == HOLD);
    assign accept     = in_valid && in_ready;
    assign out_mode   = mode_q;
    assign out_err    = err_q;
    assign out_data   = data_q;
    assign out_mask   = mask_q;
    assign out_bucket = bkt_q;

    // Decode from the shift registers with the current beat merged in, so the last beat needs no extra cycle.
    always_comb begin
        x_ins        = x_q;
        y_ins        = y_q;
        x_ins[cnt_q] = in_x;
        y_ins[cnt_q] = in_y;
        if (mode_q == MODE_SUM) begin
            dec_data = ({1'b0, x_ins} << 1) + {1'b0, y_ins};
            dec_mask = '0;
        end else begin
            dec_data = {1'b0, ~y_ins};
            dec_mask = ~y_ins;
        end
    end

    part_range_classify #(
        .WIDTH (WIDTH),
        .TH1   (TH1),
        .TH2   (TH2)
    ) u_classify (
        .data_i   (dec_data),
        .bucket_o (dec_bkt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        err_d   = err_q;
        data_d  = data_q;
        mask_d  = mask_q;
        bkt_d   = bkt_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    x_d = x_ins;
                    y_d = y_ins;
                    if (in_c != mode_q) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        data_d  = dec_data;
                        mask_d  = dec_mask;
                        bkt_d   = dec_bkt;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Beat 0 may arrive from IDLE or in the same cycle a held word is handed off.
        if (accept && (state_q != COLLECT)) begin
            x_d     = '0;
            y_d     = '0;
            x_d[0]  = in_x;
            y_d[0]  = in_y;
            mode_d  = in_c;
            err_d   = 1'b0;
            cnt_d   = CW'(1);
            state_d = (WIDTH == 1) ? HOLD : COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            bkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            bkt_q   <= bkt_d;
        end
    end

endmodule

// File: tb/tb_event_part_decoder.sv
// Directed self-checking bench for event_part_decoder with WIDTH=8, TH1=16, TH2=64.
module tb_event_part_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_x;
    logic       in_y;
    logic       in_c;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_mode;
    logic [8:0] out_data;
    logic [7:0] out_mask;
    logic [1:0] out_bucket;
    logic       out_err;

    int checks   = 0;
    int failures = 0;

    event_part_decoder #(
        .WIDTH (8),
        .TH1   (8'd16),
        .TH2   (8'd64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_c       (in_c),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mode   (out_mode),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_bucket (out_bucket),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives 8 consecutive beats on falling edges; returns on the falling edge after the last beat.
    task automatic send_word(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                             input logic rdy_after, output logic v7, output logic r0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) out_ready = 1'b1;
            in_valid = 1'b1;
            in_x     = x[i];
            in_y     = y[i];
            in_c     = c[i];
            #1;
            if (i == 0) r0 = in_ready;
            if (i == 7) v7 = out_valid;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_x      = 1'b0;
        in_y      = 1'b0;
        in_c      = 1'b0;
        out_ready = rdy_after;
    endtask

    logic v7, r0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = 1'b0;
        in_y      = 1'b0;
        in_c      = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_bucket", 32'(out_bucket), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_mask", 32'(out_mask), 32'd0);
        #9 rst_n = 1'b1;

        // a=3C, b=0F, c=0 -> a+b = 75, above TH2
        send_word(8'h0C, 8'h33, 8'h00, 1'b1, v7, r0);
        check("m0_valid_before_last", 32'(v7), 32'd0);
        check("m0_valid_latency", 32'(out_valid), 32'd1);
        check("m0_data", 32'(out_data), 32'h04B);
        check("m0_bucket", 32'(out_bucket), 32'd3);
        check("m0_mask", 32'(out_mask), 32'd0);
        check("m0_err", 32'(out_err), 32'd0);
        check("m0_mode", 32'(out_mode), 32'd0);

        send_word(8'hA5, 8'h5A, 8'hFF, 1'b1, v7, r0);
        check("m1_data", 32'(out_data), 32'h0A5);
        check("m1_mask", 32'(out_mask), 32'hA5);
        check("m1_bucket", 32'(out_bucket), 32'd3);
        check("m1_mode", 32'(out_mode), 32'd1);

        send_word(8'h00, 8'h00, 8'h00, 1'b1, v7, r0);
        check("zero_data", 32'(out_data), 32'd0);
        check("zero_bucket", 32'(out_bucket), 32'd0);
        send_word(8'h08, 8'h00, 8'h00, 1'b1, v7, r0);
        check("b16_data", 32'(out_data), 32'd16);
        check("b16_bucket", 32'(out_bucket), 32'd1);
        send_word(8'h08, 8'h01, 8'h00, 1'b1, v7, r0);
        check("b17_data", 32'(out_data), 32'd17);
        check("b17_bucket", 32'(out_bucket), 32'd2);
        send_word(8'h20, 8'h00, 8'h00, 1'b1, v7, r0);
        check("b64_data", 32'(out_data), 32'd64);
        check("b64_bucket", 32'(out_bucket), 32'd2);
        send_word(8'h20, 8'h01, 8'h00, 1'b1, v7, r0);
        check("b65_data", 32'(out_data), 32'd65);
        check("b65_bucket", 32'(out_bucket), 32'd3);

        // Back-pressure: hold 5 cycles, then release together with the next beat 0
        send_word(8'h0C, 8'h33, 8'h00, 1'b0, v7, r0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data_stable", 32'(out_data), 32'h04B);
        end
        send_word(8'hA5, 8'h5A, 8'hFF, 1'b1, v7, r0);
        check("bp_beat0_ready", 32'(r0), 32'd1);
        check("bp_next_valid_before_last", 32'(v7), 32'd0);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data", 32'(out_data), 32'h0A5);

        // c flips 1->0 from beat 4 onward
        send_word(8'hA5, 8'h5A, 8'h0F, 1'b1, v7, r0);
        check("err_flag", 32'(out_err), 32'd1);
        check("err_mode", 32'(out_mode), 32'd1);
        check("err_data", 32'(out_data), 32'h0A5);
        send_word(8'hA5, 8'h5A, 8'hFF, 1'b1, v7, r0);
        check("err_clean", 32'(out_err), 32'd0);

        // Asynchronous reset in the middle of beat 5
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 1'b1;
            in_y     = 1'b0;
            in_c     = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_data", 32'(out_data), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        send_word(8'h08, 8'h01, 8'h00, 1'b1, v7, r0);
        check("post_rst_word_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'd17);
        check("post_rst_bucket", 32'(out_bucket), 32'd2);

        @(negedge clk);
        check("final_handshake_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
